// File: rtl/safe_lock_controller.sv
// Sequencing FSM between the keypad decoder and the safe's password comparator.
// Define SAFE_LOCKOUT_EN to enable the failed-attempt LOCKOUT state and alarm.
module safe_lock_controller #(
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 500,
    parameter int LOCKOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_on,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       correct,
    input  logic [2:0] input_len,
    output logic [3:0] data,
    output logic       is_pressed,
    output logic       is_star_pressed,
    output logic       reset_password,
    output logic       clear_answer,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] fail_count,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_LOCKED  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_SET     = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [TW-1:0] OPEN_T   = TW'(OPEN_CYCLES);
    localparam logic [1:0]    FAIL_MAX = 2'(MAX_FAILS);
`ifdef SAFE_LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_T   = TW'(LOCKOUT_CYCLES);
`endif

    state_t        state_q, state_d;
    logic [1:0]    fail_q, fail_d, fail_inc_s;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    data_q, data_d;
    logic [1:0]    busy_q, busy_d;
    logic          pend_q, pend_d;
    logic          press_q, press_d;
    logic          star_q, star_d;
    logic          rpw_q, rpw_d;
    logic          clr_q, clr_d;
    logic          unlocked_q;
    logic          idle_s, k_digit_s, k_star_s, k_hash_s, k_clear_s;

    assign idle_s     = (busy_q == 2'd0);
    assign k_digit_s  = key_valid && idle_s && (key_code <= 4'd9);
    assign k_star_s   = key_valid && idle_s && (key_code == 4'hA);
    assign k_hash_s   = key_valid && idle_s && (key_code == 4'hB);
    assign k_clear_s  = key_valid && idle_s && (key_code == 4'hC);
    assign fail_inc_s = (fail_q < FAIL_MAX) ? (fail_q + 2'd1) : fail_q;

    // Next-state, pulse scheduling and the two-cycle key-drop window after any accepted key.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        data_d  = data_q;
        busy_d  = (busy_q != 2'd0) ? (busy_q - 2'd1) : 2'd0;
        pend_d  = 1'b0;
        press_d = pend_q;
        star_d  = 1'b0;
        rpw_d   = 1'b0;
        clr_d   = 1'b0;
        if (!is_on && (state_q != ST_LOCKOUT)) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_LOCKED;
                ST_LOCKED, ST_SET: begin
                    if (k_digit_s && (input_len < 3'd6)) begin
                        data_d = key_code;
                        pend_d = 1'b1;
                        busy_d = 2'd2;
                    end else if (k_star_s && (state_q == ST_LOCKED)) begin
                        state_d = ST_CHECK;
                        busy_d  = 2'd2;
                    end else if (k_star_s && (input_len >= 3'd4)) begin
                        star_d  = 1'b1;
                        state_d = ST_LOCKED;
                        fail_d  = 2'd0;
                        busy_d  = 2'd2;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CHECK: begin
                    star_d = 1'b1;
                    if (correct) begin
                        state_d = ST_OPEN;
                        fail_d  = 2'd0;
                    end else begin
                        fail_d  = fail_inc_s;
`ifdef SAFE_LOCKOUT_EN
                        state_d = (fail_inc_s == FAIL_MAX) ? ST_LOCKOUT : ST_LOCKED;
`else
                        state_d = ST_LOCKED;
`endif
                    end
                end
                ST_OPEN: begin
                    if (timer_q == OPEN_T) begin
                        state_d = ST_LOCKED;
                    end else if (k_star_s) begin
                        star_d  = 1'b1;
                        state_d = ST_LOCKED;
                        busy_d  = 2'd2;
                    end else if (k_hash_s) begin
                        rpw_d   = 1'b1;
                        state_d = ST_SET;
                        busy_d  = 2'd2;
                    end else if (k_clear_s) begin
                        clr_d   = 1'b1;
                        state_d = ST_LOCKED;
                        busy_d  = 2'd2;
                    end else begin
                        state_d = ST_OPEN;
                    end
                end
`ifdef SAFE_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer_q == LOCK_T) begin
                        state_d = ST_LOCKED;
                        fail_d  = 2'd0;
                    end else begin
                        state_d = ST_LOCKOUT;
                    end
                end
`endif
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Dwell timer restarts at 1 on every state change; only OPEN and LOCKOUT consume it.
    always_comb begin
        if (state_d != state_q) begin
            timer_d = T_ONE;
        end else if ((state_q == ST_OPEN) || (state_q == ST_LOCKOUT)) begin
            timer_d = timer_q + T_ONE;
        end else begin
            timer_d = timer_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OFF;
            fail_q     <= 2'd0;
            timer_q    <= {TW{1'b0}};
            data_q     <= 4'd0;
            busy_q     <= 2'd0;
            pend_q     <= 1'b0;
            press_q    <= 1'b0;
            star_q     <= 1'b0;
            rpw_q      <= 1'b0;
            clr_q      <= 1'b0;
            unlocked_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            press_q    <= press_d;
            star_q     <= star_d;
            rpw_q      <= rpw_d;
            clr_q      <= clr_d;
            unlocked_q <= (state_d == ST_OPEN);
        end
    end

`ifdef SAFE_LOCKOUT_EN
    logic alarm_q;

    // Alarm indicator follows entry into LOCKOUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= (state_d == ST_LOCKOUT);
        end
    end
    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

    assign data            = data_q;
    assign is_pressed      = press_q;
    assign is_star_pressed = star_q;
    assign reset_password  = rpw_q;
    assign clear_answer    = clr_q;
    assign unlocked        = unlocked_q;
    assign fail_count      = fail_q;
    assign state           = state_q;
endmodule

// File: tb/tb_safe_lock_controller.sv
// Directed self-checking bench for safe_lock_controller; the bench plays the comparator role.
module tb_safe_lock_controller;
    localparam int MAXF = 3;
    localparam int OPENC = 500;
    localparam int LOCKC = 1000;

    logic       clk = 1'b0;
    logic       reset, is_on, key_valid, correct;
    logic [3:0] key_code;
    logic [2:0] input_len;
    logic [3:0] data;
    logic       is_pressed, is_star_pressed, reset_password, clear_answer, unlocked, alarm;
    logic [1:0] fail_count;
    logic [2:0] state;
    int         checks = 0;
    int         errors = 0;

    safe_lock_controller #(.MAX_FAILS(MAXF), .OPEN_CYCLES(OPENC), .LOCKOUT_CYCLES(LOCKC)) dut (
        .clk(clk), .reset(reset), .is_on(is_on), .key_valid(key_valid), .key_code(key_code),
        .correct(correct), .input_len(input_len), .data(data), .is_pressed(is_pressed),
        .is_star_pressed(is_star_pressed), .reset_password(reset_password),
        .clear_answer(clear_answer), .unlocked(unlocked), .alarm(alarm),
        .fail_count(fail_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; is_on = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        correct = 1'b0; input_len = 3'd0;
        repeat (2) tick();
        chk("rst_state", state, 0);
        chk("rst_data", data, 0);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_fail", fail_count, 0);
        chk("rst_pulses", {is_pressed, is_star_pressed, reset_password, clear_answer}, 0);
        reset = 1'b0;
        tick();
        chk("off_hold", state, 0);
        is_on = 1'b1;
        tick();
        chk("power_on", state, 1);

        // digit forwarding with a dropped strobe at N+1
        press(4'd7);
        chk("d7_data", data, 7);
        chk("d7_nopulse", is_pressed, 0);
        key_valid = 1'b1; key_code = 4'd3;
        tick();
        key_valid = 1'b0;
        chk("d7_pulse", is_pressed, 1);
        tick();
        chk("d7_pulse_end", is_pressed, 0);
        chk("d7_drop_data", data, 7);
        tick();
        chk("d7_drop_pulse", is_pressed, 0);

        // six digits then correct star
        input_len = 3'd0;
        for (int i = 0; i < 6; i++) begin
            press(4'd0);
            tick();
            chk("dig_pulse", is_pressed, 1);
            input_len = input_len + 3'd1;
            tick();
        end
        press(4'd5);
        chk("full_data", data, 0);
        tick();
        chk("full_nopulse", is_pressed, 0);
        tick();
        correct = 1'b1;
        press(4'hA);
        chk("check_state", state, 2);
        chk("check_nostar", is_star_pressed, 0);
        tick();
        correct = 1'b0; input_len = 3'd0;
        chk("open_state", state, 3);
        chk("open_unlocked", unlocked, 1);
        chk("open_star", is_star_pressed, 1);
        chk("open_fail", fail_count, 0);
        repeat (OPENC - 1) tick();
        chk("open_last", unlocked, 1);
        tick();
        chk("relock_unlocked", unlocked, 0);
        chk("relock_state", state, 1);

        // consecutive wrong attempts
        for (int i = 1; i <= MAXF; i++) begin
            press(4'hA);
            tick();
            chk("wrong_fail", fail_count, i);
            chk("wrong_star", is_star_pressed, 1);
`ifdef SAFE_LOCKOUT_EN
            chk("wrong_state", state, (i == MAXF) ? 5 : 1);
            chk("wrong_alarm", alarm, (i == MAXF) ? 1 : 0);
`else
            chk("wrong_state", state, 1);
            chk("wrong_alarm", alarm, 0);
`endif
            if (i < MAXF) tick();
        end
`ifdef SAFE_LOCKOUT_EN
        tick();
        press(4'hA);
        chk("lo_key_state", state, 5);
        chk("lo_key_star", is_star_pressed, 0);
        tick();
        press(4'd4);
        tick();
        chk("lo_key_digit", is_pressed, 0);
        is_on = 1'b0;
        tick();
        chk("lo_power", state, 5);
        is_on = 1'b1;
        repeat (LOCKC - 7) tick();
        chk("lo_last_alarm", alarm, 1);
        chk("lo_last_state", state, 5);
        tick();
        chk("lo_exit_state", state, 1);
        chk("lo_exit_alarm", alarm, 0);
        chk("lo_exit_fail", fail_count, 0);
`else
        tick();
        press(4'hA);
        tick();
        chk("sat_fail", fail_count, 3);
        chk("sat_state", state, 1);
        chk("sat_alarm", alarm, 0);
`endif
        tick();

        // password change path
        correct = 1'b1;
        press(4'hA);
        tick();
        correct = 1'b0;
        chk("pc_open", state, 3);
        chk("pc_fail", fail_count, 0);
        tick();
        press(4'hB);
        chk("pc_rpw", reset_password, 1);
        chk("pc_set", state, 4);
        chk("pc_unlocked", unlocked, 0);
        tick();
        chk("pc_rpw_end", reset_password, 0);
        tick();
        input_len = 3'd3;
        press(4'hA);
        chk("set_short_star", is_star_pressed, 0);
        chk("set_short_state", state, 4);
        input_len = 3'd5;
        press(4'hA);
        chk("set_commit_star", is_star_pressed, 1);
        chk("set_commit_state", state, 1);
        tick();
        chk("set_star_end", is_star_pressed, 0);
        tick();
        input_len = 3'd0;

        // factory clear from OPEN
        correct = 1'b1;
        press(4'hA);
        tick();
        correct = 1'b0;
        tick();
        press(4'hC);
        chk("fc_pulse", clear_answer, 1);
        chk("fc_state", state, 1);
        tick();
        chk("fc_pulse_end", clear_answer, 0);
        tick();

        // power removal
        correct = 1'b1;
        press(4'hA);
        tick();
        correct = 1'b0;
        is_on = 1'b0;
        tick();
        chk("pw_open_state", state, 0);
        chk("pw_open_unlocked", unlocked, 0);
        is_on = 1'b1;
        tick();
        press(4'hA);
        tick();
        chk("pw_wrong_fail", fail_count, 1);
        tick();
        is_on = 1'b0;
        press(4'hA);
        chk("pw_beats_key", state, 0);
        chk("pw_keep_fail", fail_count, 1);
        press(4'hA);
        chk("off_ignores_key", state, 0);
        is_on = 1'b1;
        tick();
        chk("pw_back", state, 1);

        // reset during CHECK
        press(4'hA);
        chk("rc_check", state, 2);
        reset = 1'b1;
        tick();
        chk("rc_state", state, 0);
        chk("rc_nostar", is_star_pressed, 0);
        chk("rc_fail", fail_count, 0);
        reset = 1'b0;
        tick();
        chk("rc_nostar_late", is_star_pressed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
